ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage RV32 pipeline, sitting between the ID/EX register and the MEM stage. It resolves operands using the `forward_a`/`forward_b` selects from the forwarding unit and computes the ALU result. It registers results into the EX/MEM pipeline register with valid, stall and flush control. An optional iterative multiplier stalls the front end while it runs.

## Interface
- `XLEN`, 32, datapath width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: ID/EX holds a real instruction.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm` in XLEN each: ID/EX operands.
- `ex_alu_op` in 4: ALU operation, encoded per the shared package.
- `alua_sel` in 1: 1 selects `ex_pc` as A, 0 selects the forwarded rs1.
- `alub_sel` in 1: 1 selects `ex_imm` as B, 0 selects the forwarded rs2.
- `ex_rf_we`, `ex_mem_we`, `ex_mem_re` in 1: control bits carried to MEM.
- `ex_wR` in 5: destination register.
- `forward_a`, `forward_b` in 2: 00 selects ID/EX data, 01 selects `mem_fwd_data`, 10 selects `wb_fwd_data`, 11 is treated as 00.
- `mem_fwd_data`, `wb_fwd_data` in XLEN: forwarding sources.
- `mem_stall` in 1: MEM cannot accept; EX/MEM holds.
- `flush` in 1: kill the EX instruction (branch or trap redirect).
- `ex_stall_req` out 1: hold IF/ID/ID/EX this cycle.
- `mem_valid` out 1: EX/MEM valid.
- `mem_alu_result`, `mem_store_data` out XLEN: EX/MEM data.
- `mem_wR` out 5; `mem_rf_we`, `mem_mem_we`, `mem_mem_re` out 1: EX/MEM control.

## Operation
- Operand A: `alua_sel ? ex_pc : fwdA`. Operand B: `alub_sel ? ex_imm : fwdB`. Store data is always `fwdB`.
- ALU ops:
  - ADD and SUB wrap modulo 2^XLEN.
  - AND, OR, XOR.
  - SLL, SRL, SRA use shift amount B[4:0].
  - SLT is signed and SLTU is unsigned; both produce 0 or 1.
  - PASSB implements LUI.
  - MUL returns the low XLEN bits of the product.
  - Undefined codes yield 0.
- EX/MEM update priority, highest first:
  1. Reset: all outputs 0.
  2. `flush`: `mem_valid`, `mem_rf_we`, `mem_mem_we` and `mem_mem_re` go to 0; data fields may change.
  3. `mem_stall`: hold every field.
  4. `ex_stall_req`: insert a bubble, with valid and all write/read enables at 0.
  5. Otherwise capture the EX values, with valid set to `ex_valid`. When `ex_valid` is 0, all enables are 0.
- Multiplier FSM (compiled in only with MUL_EXT_EN):
  - States are IDLE, BUSY and DONE.
  - IDLE → BUSY when `ex_valid` and op is MUL. In that cycle, latch A, B and the control bits, load the counter with XLEN-1, and raise `ex_stall_req`.
  - BUSY does one shift-add step per cycle with `ex_stall_req` high. When the counter reaches 0, go to DONE.
  - DONE drops `ex_stall_req` and presents the product to EX/MEM. Move to IDLE on the first cycle with `mem_stall` 0; stay in DONE while `mem_stall` is 1.
  - `flush` in any state → IDLE next edge, dropping the product.
- Operands are latched at MUL acceptance because the forwarding sources keep advancing while EX is stalled.
- Non-MUL ops never raise `ex_stall_req`.

## Timing
- Single-cycle ALU ops: inputs in cycle T appear on EX/MEM outputs after edge T+1.
- MUL accepted in cycle T:
  - `ex_stall_req` is high for cycles T through T+XLEN.
  - DONE is cycle T+XLEN+1; the result is on the outputs after edge T+XLEN+2.
  - For XLEN=32 this is 34 cycles in EX.
- Reset mid-MUL: FSM goes to IDLE and `ex_stall_req` to 0 immediately (asynchronous).
- `flush` and `mem_stall` together: flush wins.
- `flush` in the same cycle as MUL acceptance: no stall on the next cycle.

## Configuration
- `MUL_EXT_EN` defined: the multiplier FSM and sub-module are present.
- `MUL_EXT_EN` undefined:
  - The MUL code yields a result of 0.
  - `ex_stall_req` is tied to 0.
  - No FSM state exists.

## Structure
- Shared package `pipe_pkg` holds:
  - the ALU op codes (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10, MUL=11);
  - the forward select constants (FWD_ID=00, FWD_MEM=01, FWD_WB=10);
  - the multiplier state encoding.
- One sub-module, `mul_iter`, holds the radix-2 shift-add datapath, the counter, start/done and abort. `ex_stage` owns the FSM's stall and handshake.

## Test plan
- Forward select 01:
  - `forward_a`=01, `mem_fwd_data`=0x10, `ex_imm`=5, `alub_sel`=1, op ADD → `mem_alu_result`=0x15 and `mem_valid`=1 after one edge.
- Forward select 10 on store data:
  - `forward_b`=10, `wb_fwd_data`=0xDEADBEEF, `ex_mem_we`=1 → `mem_store_data`=0xDEADBEEF.
- SRA and SLTU:
  - A=0x80000000, B=4, op SRA → 0xF8000000.
  - A=1, B=0xFFFFFFFF, op SLTU → 1.
- MUL, with MUL_EXT_EN defined:
  - A=7, B=0xFFFFFFFF (−1) → `ex_stall_req` high for exactly 33 cycles.
  - Result 0xFFFFFFF9.
  - Bubbles (`mem_valid`=0) are emitted during the stall.
- Flush mid-MUL at BUSY cycle 10 → FSM is IDLE next cycle, `ex_stall_req`=0, and no MUL result ever appears with `mem_valid`=1.
- Hold versus flush:
  - `mem_stall`=1 holds all EX/MEM outputs for 3 cycles.
  - `mem_stall`=1 together with `flush`=1 → `mem_valid`=0.
  - Asserting `rst_n`=0 asynchronously zeroes all outputs.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op codes, forwarding selects and the
// multiplier FSM state encoding.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: XLEN steps after start, low XLEN product bits.
// Present only when MUL_EXT_EN is defined.
`ifdef MUL_EXT_EN
module mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] mcand, mplier, acc;
  logic [CW-1:0]   cnt;
  logic            run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(XLEN - 1);
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) run <= 1'b0;
    end
  end

  // done marks the cycle performing the final step; product is valid after it
  assign done    = run && (cnt == '0);
  assign product = acc;

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU and EX/MEM register.
// Define MUL_EXT_EN to build the iterative multiplier and its stall FSM.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [3:0]      ex_alu_op,
  input  logic            alua_sel,
  input  logic            alub_sel,
  input  logic            ex_rf_we,
  input  logic            ex_mem_we,
  input  logic            ex_mem_re,
  input  logic [4:0]      ex_wR,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            ex_stall_req,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_wR,
  output logic            mem_rf_we,
  output logic            mem_mem_we,
  output logic            mem_mem_re
);

  alu_op_e         op;
  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic            cap_valid, cap_rf_we, cap_mem_we, cap_mem_re;
  logic [XLEN-1:0] cap_result, cap_store;
  logic [4:0]      cap_wR;

  assign op = alu_op_e'(ex_alu_op);

  always_comb begin
    case (forward_a)
      FWD_MEM: fwd_a = mem_fwd_data;
      FWD_WB:  fwd_a = wb_fwd_data;
      default: fwd_a = ex_rs1_data;
    endcase
    case (forward_b)
      FWD_MEM: fwd_b = mem_fwd_data;
      FWD_WB:  fwd_b = wb_fwd_data;
      default: fwd_b = ex_rs2_data;
    endcase
  end

  assign op_a = alua_sel ? ex_pc  : fwd_a;
  assign op_b = alub_sel ? ex_imm : fwd_b;

  // MUL is not computed here; it comes from the iterative unit when present
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

`ifdef MUL_EXT_EN
  mul_state_e      state, state_nxt;
  logic            mul_start, mul_done;
  logic [XLEN-1:0] mul_prod, l_store;
  logic [4:0]      l_wR;
  logic            l_rf_we, l_mem_we, l_mem_re;

  // rst_n gates acceptance so the stall request drops the moment reset asserts
  assign mul_start = rst_n && (state == MUL_IDLE) && ex_valid && (op == ALU_MUL) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: if (mul_start)  state_nxt = MUL_BUSY;
        MUL_BUSY: if (mul_done)   state_nxt = MUL_DONE;
        MUL_DONE: if (!mem_stall) state_nxt = MUL_IDLE;
        default:  state_nxt = MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_stall_req = mul_start || (state == MUL_BUSY);
  end

  // Forwarding sources keep moving during the stall, so capture everything at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_store  <= '0;
      l_wR     <= '0;
      l_rf_we  <= 1'b0;
      l_mem_we <= 1'b0;
      l_mem_re <= 1'b0;
    end else if (mul_start) begin
      l_store  <= fwd_b;
      l_wR     <= ex_wR;
      l_rf_we  <= ex_rf_we;
      l_mem_we <= ex_mem_we;
      l_mem_re <= ex_mem_re;
    end
  end

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign ex_stall_req = 1'b0;
`endif

  always_comb begin
    cap_valid  = ex_valid;
    cap_result = alu_res;
    cap_store  = fwd_b;
    cap_wR     = ex_wR;
    cap_rf_we  = ex_valid & ex_rf_we;
    cap_mem_we = ex_valid & ex_mem_we;
    cap_mem_re = ex_valid & ex_mem_re;
`ifdef MUL_EXT_EN
    if (state == MUL_DONE) begin
      cap_valid  = 1'b1;
      cap_result = mul_prod;
      cap_store  = l_store;
      cap_wR     = l_wR;
      cap_rf_we  = l_rf_we;
      cap_mem_we = l_mem_we;
      cap_mem_re = l_mem_re;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_wR         <= '0;
      mem_rf_we      <= 1'b0;
      mem_mem_we     <= 1'b0;
      mem_mem_re     <= 1'b0;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_rf_we  <= 1'b0;
      mem_mem_we <= 1'b0;
      mem_mem_re <= 1'b0;
    end else if (!mem_stall) begin
      if (ex_stall_req) begin
        mem_valid  <= 1'b0;
        mem_rf_we  <= 1'b0;
        mem_mem_we <= 1'b0;
        mem_mem_re <= 1'b0;
      end else begin
        mem_valid      <= cap_valid;
        mem_alu_result <= cap_result;
        mem_store_data <= cap_store;
        mem_wR         <= cap_wR;
        mem_rf_we      <= cap_rf_we;
        mem_mem_we     <= cap_mem_we;
        mem_mem_re     <= cap_mem_re;
      end
    end
  end

endmodule
